// File: rtl/mem_sched_pkg.sv
// mem_sched shared sizes, tag table types and the issue bundle.
// Optional instr aging is selected by MEM_SCHED_AGING_EN.
package mem_sched_pkg;

  localparam int PA_WIDTH   = 32;
  localparam int LINE_WIDTH = 128;
  localparam int ID_WIDTH   = 2;
  localparam int NUM_TAGS   = 2 ** ID_WIDTH;
  localparam int AGE_LIMIT  = 4;
  localparam int AGE_WIDTH  = $clog2(AGE_LIMIT + 1);

  typedef enum logic {
    OWN_INSTR,
    OWN_DATA
  } mem_owner_t;

  typedef struct packed {
    logic       valid;
    mem_owner_t owner;
  } tag_entry_t;

  typedef logic [ID_WIDTH-1:0] tag_id_t;
  typedef logic [NUM_TAGS-1:0] tag_vec_t;

  typedef struct packed {
    logic                  en;
    logic                  wr;
    logic [PA_WIDTH-1:0]   addr;
    logic [LINE_WIDTH-1:0] data;
    tag_id_t               id;
  } mem_issue_t;

  function automatic tag_vec_t tag_onehot(
    input tag_id_t id
  );
    return tag_vec_t'(1) << id;
  endfunction

endpackage

// File: rtl/mem_sched_if.sv
// Requester, memory and response signals of mem_sched.
// slave = scheduler side, master = requesters/memory side.
interface mem_sched_if;
  import mem_sched_pkg::*;

  logic                  i_instr_enable;
  logic [PA_WIDTH-1:0]   i_instr_addr;
  logic                  o_instr_grant;
  tag_id_t               o_instr_id;
  logic                  i_data_enable;
  logic                  i_data_write;
  logic [PA_WIDTH-1:0]   i_data_addr;
  logic [LINE_WIDTH-1:0] i_data;
  logic                  o_data_grant;
  tag_id_t               o_data_id;
  logic                  o_mem_enable;
  logic                  o_mem_write;
  logic [PA_WIDTH-1:0]   o_mem_addr;
  logic [LINE_WIDTH-1:0] o_mem_data;
  tag_id_t               o_mem_id;
  logic                  i_mem_full;
  logic                  i_resp_enable;
  tag_id_t               i_resp_id;
  logic                  o_resp_instr;
  logic                  o_resp_data;
  logic                  i_ack_instr;
  logic                  i_ack_data;
  logic                  o_tags_full;
  logic                  o_spurious;

  modport slave (
    input  i_instr_enable, i_instr_addr,
    input  i_data_enable, i_data_write,
    input  i_data_addr, i_data,
    input  i_mem_full, i_resp_enable, i_resp_id,
    input  i_ack_instr, i_ack_data,
    output o_instr_grant, o_instr_id,
    output o_data_grant, o_data_id,
    output o_mem_enable, o_mem_write,
    output o_mem_addr, o_mem_data, o_mem_id,
    output o_resp_instr, o_resp_data,
    output o_tags_full, o_spurious
  );

  modport master (
    output i_instr_enable, i_instr_addr,
    output i_data_enable, i_data_write,
    output i_data_addr, i_data,
    output i_mem_full, i_resp_enable, i_resp_id,
    output i_ack_instr, i_ack_data,
    input  o_instr_grant, o_instr_id,
    input  o_data_grant, o_data_id,
    input  o_mem_enable, o_mem_write,
    input  o_mem_addr, o_mem_data, o_mem_id,
    input  o_resp_instr, o_resp_data,
    input  o_tags_full, o_spurious
  );

endinterface

// File: rtl/mem_sched_tag_alloc.sv
// Tag free bitmap with lowest-free encoder.
// Frees land at the edge, so a freed tag is offered next cycle.
module mem_sched_tag_alloc
  import mem_sched_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     alloc,
  input  tag_vec_t free_mask,
  output tag_vec_t valid,
  output tag_id_t  free_id,
  output logic     has_free,
  output logic     full
);

  tag_vec_t valid_n;

  always_comb begin
    free_id = '0;
    for (int k = NUM_TAGS - 1; k >= 0; k--) begin
      if (!valid[k]) free_id = tag_id_t'(k);
    end
  end

  assign has_free = ~&valid;

  always_comb begin
    valid_n = valid & ~free_mask;
    if (alloc) valid_n = valid_n | tag_onehot(free_id);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
      full  <= 1'b0;
    end else begin
      valid <= valid_n;
      full  <= &valid_n;
    end
  end

endmodule

// File: rtl/mem_sched.sv
// Shared memory port scheduler for instr/data requesters.
// MEM_SCHED_AGING_EN enables instr promotion after AGE_LIMIT losses.
module mem_sched
  import mem_sched_pkg::*;
(
  input logic        clk,
  input logic        rst,
  mem_sched_if.slave bus
);

  tag_vec_t   valid;
  tag_vec_t   free_mask;
  tag_id_t    free_id;
  tag_id_t    lid_i;
  tag_id_t    lid_d;
  logic       has_free;
  logic       full;
  mem_owner_t owner_q [NUM_TAGS];
  tag_entry_t tag_tab [NUM_TAGS];
  tag_entry_t resp_ent;
  logic       elig_i;
  logic       elig_d;
  logic       gnt_i;
  logic       gnt_d;
  logic       promote;
  logic       alloc;
  logic       ack_ok_i;
  logic       ack_ok_d;
  logic       spur_set;
  logic       spur_q;
  mem_issue_t issue_n;
  mem_issue_t issue_q;

  mem_sched_tag_alloc u_tags (
    .clk       (clk),
    .rst       (rst),
    .alloc     (alloc),
    .free_mask (free_mask),
    .valid     (valid),
    .free_id   (free_id),
    .has_free  (has_free),
    .full      (full)
  );

  always_comb begin
    for (int k = 0; k < NUM_TAGS; k++) begin
      tag_tab[k].valid = valid[k];
      tag_tab[k].owner = owner_q[k];
    end
  end

  assign elig_i = bus.i_instr_enable
                & ~bus.i_mem_full
                & has_free;
  assign elig_d = bus.i_data_enable
                & ~bus.i_mem_full
                & (bus.i_data_write | has_free);

  assign gnt_i = elig_i & (~elig_d | promote);
  assign gnt_d = elig_d & ~gnt_i;
  assign alloc = gnt_i | (gnt_d & ~bus.i_data_write);

  assign bus.o_instr_grant = gnt_i;
  assign bus.o_instr_id    = free_id;
  assign bus.o_data_grant  = gnt_d;
  assign bus.o_data_id     = free_id;

`ifdef MEM_SCHED_AGING_EN
  logic [AGE_WIDTH-1:0] age_cnt;

  assign promote = (age_cnt == AGE_WIDTH'(AGE_LIMIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      age_cnt <= '0;
    end else if (gnt_i) begin
      age_cnt <= '0;
    end else if (elig_i && !promote) begin
      age_cnt <= age_cnt + 1'b1;
    end
  end
`else
  assign promote = 1'b0;
`endif

  assign resp_ent = tag_tab[bus.i_resp_id];

  assign bus.o_resp_instr = bus.i_resp_enable
                          & resp_ent.valid
                          & (resp_ent.owner == OWN_INSTR);
  assign bus.o_resp_data  = bus.i_resp_enable
                          & resp_ent.valid
                          & (resp_ent.owner == OWN_DATA);

  // An ack frees the tag last routed to that owner, if still held by it.
  assign ack_ok_i = tag_tab[lid_i].valid
                  & (tag_tab[lid_i].owner == OWN_INSTR);
  assign ack_ok_d = tag_tab[lid_d].valid
                  & (tag_tab[lid_d].owner == OWN_DATA);

  always_comb begin
    free_mask = '0;
    if (bus.i_ack_instr && ack_ok_i)
      free_mask = free_mask | tag_onehot(lid_i);
    if (bus.i_ack_data && ack_ok_d)
      free_mask = free_mask | tag_onehot(lid_d);
  end

  assign spur_set = (bus.i_resp_enable & ~resp_ent.valid)
                  | (bus.i_ack_instr & ~ack_ok_i)
                  | (bus.i_ack_data & ~ack_ok_d);

  always_comb begin
    issue_n = '0;
    unique case (1'b1)
      gnt_i: begin
        issue_n.en   = 1'b1;
        issue_n.addr = bus.i_instr_addr;
        issue_n.id   = free_id;
      end
      gnt_d: begin
        issue_n.en   = 1'b1;
        issue_n.wr   = bus.i_data_write;
        issue_n.addr = bus.i_data_addr;
        if (bus.i_data_write)
          issue_n.data = bus.i_data;
        else
          issue_n.id = free_id;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_TAGS; k++)
        owner_q[k] <= OWN_INSTR;
    end else if (alloc) begin
      owner_q[free_id] <= gnt_i ? OWN_INSTR : OWN_DATA;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lid_i   <= '0;
      lid_d   <= '0;
      spur_q  <= 1'b0;
      issue_q <= '0;
    end else begin
      if (bus.o_resp_instr) lid_i <= bus.i_resp_id;
      if (bus.o_resp_data)  lid_d <= bus.i_resp_id;
      spur_q  <= spur_q | spur_set;
      issue_q <= issue_n;
    end
  end

  assign bus.o_mem_enable = issue_q.en;
  assign bus.o_mem_write  = issue_q.wr;
  assign bus.o_mem_addr   = issue_q.addr;
  assign bus.o_mem_data   = issue_q.data;
  assign bus.o_mem_id     = issue_q.id;
  assign bus.o_tags_full  = full;
  assign bus.o_spurious   = spur_q;

endmodule

// File: tb/tb_mem_sched.sv
// Bench for mem_sched: directed scenarios plus random traffic
// against a table-level reference model of the scheduler.
module tb_mem_sched;
  import mem_sched_pkg::*;

`ifdef MEM_SCHED_AGING_EN
  localparam bit AGING = 1'b1;
`else
  localparam bit AGING = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mem_sched_if bus ();

  mem_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model state: table, owners (1 = data), last ids
  bit           mv [NUM_TAGS];
  bit           mo [NUM_TAGS];
  int           age, lid_i, lid_d, lo, win;
  bit           anyfree, ei, ed, r_i, r_d, spur, sp_new;
  bit           e_men, e_mwr, eg_i, eg_d;
  logic [31:0]  e_maddr;
  logic [127:0] e_mdata;
  int           e_mid;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NUM_TAGS; k++) begin
        mv[k] = 1'b0;
        mo[k] = 1'b0;
      end
      age = 0; lid_i = 0; lid_d = 0; spur = 1'b0;
      e_men = 1'b0; e_mwr = 1'b0; e_maddr = '0;
      e_mdata = '0; e_mid = 0; eg_i = 1'b0; eg_d = 1'b0;
      chk("rst_mem_en", bus.o_mem_enable, 0);
      chk("rst_full", bus.o_tags_full, 0);
      chk("rst_spur", bus.o_spurious, 0);
    end else begin
      anyfree = 1'b0;
      lo = 0;
      for (int k = NUM_TAGS - 1; k >= 0; k--)
        if (!mv[k]) begin anyfree = 1'b1; lo = k; end
      ei = bus.i_instr_enable && !bus.i_mem_full && anyfree;
      ed = bus.i_data_enable && !bus.i_mem_full &&
           (bus.i_data_write || anyfree);
      if (ei && ed) win = (AGING && age >= AGE_LIMIT) ? 1 : 2;
      else if (ei)  win = 1;
      else if (ed)  win = 2;
      else          win = 0;
      r_i = bus.i_resp_enable && mv[bus.i_resp_id] && !mo[bus.i_resp_id];
      r_d = bus.i_resp_enable && mv[bus.i_resp_id] && mo[bus.i_resp_id];

      chk("instr_grant", bus.o_instr_grant, win == 1);
      chk("data_grant", bus.o_data_grant, win == 2);
      if (win == 1) chk("instr_id", bus.o_instr_id, lo);
      if (win == 2 && !bus.i_data_write)
        chk("data_id", bus.o_data_id, lo);
      chk("resp_instr", bus.o_resp_instr, r_i);
      chk("resp_data", bus.o_resp_data, r_d);
      chk("tags_full", bus.o_tags_full, !anyfree);
      chk("spurious", bus.o_spurious, spur);
      chk("mem_enable", bus.o_mem_enable, e_men);
      if (e_men) begin
        chk("mem_write", bus.o_mem_write, e_mwr);
        chk("mem_addr", bus.o_mem_addr, e_maddr);
        chk("mem_id", bus.o_mem_id, e_mid);
      end
      if (e_mwr) chk("mem_data", bus.o_mem_data, e_mdata);

      sp_new = (bus.i_resp_enable && !mv[bus.i_resp_id]) ||
               (bus.i_ack_instr && !(mv[lid_i] && !mo[lid_i])) ||
               (bus.i_ack_data && !(mv[lid_d] && mo[lid_d]));
      if (bus.i_ack_instr && mv[lid_i] && !mo[lid_i]) mv[lid_i] = 1'b0;
      if (bus.i_ack_data && mv[lid_d] && mo[lid_d])   mv[lid_d] = 1'b0;
      e_mwr = (win == 2) && bus.i_data_write;
      if (win == 1 || (win == 2 && !e_mwr)) begin
        mv[lo] = 1'b1;
        mo[lo] = (win == 2);
      end
      if (r_i) lid_i = int'(bus.i_resp_id);
      if (r_d) lid_d = int'(bus.i_resp_id);
      if (win == 1)                   age = 0;
      else if (ei && age < AGE_LIMIT) age++;
      e_men   = (win != 0);
      e_maddr = (win == 1) ? bus.i_instr_addr : bus.i_data_addr;
      e_mid   = (e_men && !e_mwr) ? lo : 0;
      e_mdata = e_mwr ? bus.i_data : '0;
      eg_i    = (win == 1);
      eg_d    = (win == 2);
      spur    = spur | sp_new;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_instr_enable = 1'b0;
    bus.i_instr_addr   = '0;
    bus.i_data_enable  = 1'b0;
    bus.i_data_write   = 1'b0;
    bus.i_data_addr    = '0;
    bus.i_data         = '0;
    bus.i_mem_full     = 1'b0;
    bus.i_resp_enable  = 1'b0;
    bus.i_resp_id      = '0;
    bus.i_ack_instr    = 1'b0;
    bus.i_ack_data     = 1'b0;
  endtask

  task automatic do_reset();
    cyc();
    clear_inputs();
    rst = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  logic [127:0] line;
  int           t;

  initial begin
    rst = 1'b0;
    clear_inputs();
    repeat (3) cyc();
    mid();
    chk("reset_mem_en", bus.o_mem_enable, 0);
    chk("reset_full", bus.o_tags_full, 0);
    chk("reset_spur", bus.o_spurious, 0);
    cyc();
    rst = 1'b1;

    // data beats instr, then instr follows with the next tag
    cyc();
    bus.i_instr_enable = 1'b1; bus.i_instr_addr = 32'h100;
    bus.i_data_enable  = 1'b1; bus.i_data_addr  = 32'h200;
    mid();
    chk("b_dgrant", bus.o_data_grant, 1);
    chk("b_did", bus.o_data_id, 0);
    chk("b_igrant0", bus.o_instr_grant, 0);
    cyc();
    bus.i_data_enable = 1'b0;
    mid();
    chk("b_mem_en", bus.o_mem_enable, 1);
    chk("b_mem_addr", bus.o_mem_addr, 32'h200);
    chk("b_mem_id", bus.o_mem_id, 0);
    chk("b_igrant", bus.o_instr_grant, 1);
    chk("b_iid", bus.o_instr_id, 1);
    cyc();
    bus.i_instr_enable = 1'b0;
    mid();
    chk("b_mem_addr_i", bus.o_mem_addr, 32'h100);
    chk("b_mem_id_i", bus.o_mem_id, 1);

    // reset drops outstanding tags; a late response is spurious
    cyc();
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    bus.i_resp_enable = 1'b1; bus.i_resp_id = 2'd1;
    mid();
    chk("c_resp_i", bus.o_resp_instr, 0);
    chk("c_resp_d", bus.o_resp_data, 0);
    cyc();
    bus.i_resp_enable = 1'b0;
    mid();
    chk("c_spur", bus.o_spurious, 1);
    do_reset();
    mid();
    chk("c_spur_clr", bus.o_spurious, 0);

    // instr starved by a continuous store stream
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (k == 1) bus.i_instr_enable = 1'b1;
      if (eg_i) bus.i_instr_enable = 1'b0;
      bus.i_data_enable = 1'b1;
      bus.i_data_write  = 1'b1;
      bus.i_data_addr   = 32'h800 + 32'(k);
      mid();
      chk("d_age_igrant", bus.o_instr_grant, AGING && k == 5);
      chk("d_age_dgrant", bus.o_data_grant, !(AGING && k == 5));
    end
    do_reset();

    // fill all tags with instr reads, then only stores get through
    for (int k = 0; k < NUM_TAGS; k++) begin
      cyc();
      bus.i_instr_enable = 1'b1;
      bus.i_instr_addr   = 32'h1000 + 32'(k * 16);
      mid();
      chk("e_fill_grant", bus.o_instr_grant, 1);
      chk("e_fill_id", bus.o_instr_id, k);
    end
    cyc();
    bus.i_instr_addr = 32'h1040;
    mid();
    chk("e_full", bus.o_tags_full, 1);
    chk("e_5th", bus.o_instr_grant, 0);
    cyc();
    line = {32'hdead_beef, 32'h0123_4567, 32'h89ab_cdef, 32'h5a5a_a5a5};
    bus.i_data_enable = 1'b1; bus.i_data_write = 1'b1;
    bus.i_data_addr = 32'h300; bus.i_data = line;
    mid();
    chk("e_store_grant", bus.o_data_grant, 1);
    cyc();
    bus.i_data_enable = 1'b0; bus.i_instr_enable = 1'b0;
    mid();
    chk("e_st_en", bus.o_mem_enable, 1);
    chk("e_st_wr", bus.o_mem_write, 1);
    chk("e_st_addr", bus.o_mem_addr, 32'h300);
    chk("e_st_data", bus.o_mem_data, line);
    do_reset();

    // response routing and free timing of a data tag
    cyc();
    bus.i_instr_enable = 1'b1; bus.i_instr_addr = 32'h400;
    mid();
    chk("f_id0", bus.o_instr_id, 0);
    cyc();
    bus.i_instr_addr = 32'h410;
    mid();
    chk("f_id1", bus.o_instr_id, 1);
    cyc();
    bus.i_instr_enable = 1'b0;
    bus.i_data_enable = 1'b1; bus.i_data_write = 1'b0;
    bus.i_data_addr = 32'h500;
    mid();
    chk("f_did2", bus.o_data_id, 2);
    cyc();
    bus.i_data_enable = 1'b0;
    bus.i_resp_enable = 1'b1; bus.i_resp_id = 2'd2;
    mid();
    chk("f_resp_d", bus.o_resp_data, 1);
    chk("f_resp_i", bus.o_resp_instr, 0);
    cyc();
    bus.i_resp_enable = 1'b0; bus.i_ack_data = 1'b1;
    bus.i_instr_enable = 1'b1; bus.i_instr_addr = 32'h420;
    mid();
    chk("f_nobypass_g", bus.o_instr_grant, 1);
    chk("f_nobypass_id", bus.o_instr_id, 3);
    cyc();
    bus.i_ack_data = 1'b0; bus.i_instr_addr = 32'h430;
    mid();
    chk("f_realloc", bus.o_instr_id, 2);

    // memory back-pressure blocks every grant
    cyc();
    bus.i_instr_enable = 1'b0;
    bus.i_data_enable = 1'b1; bus.i_data_write = 1'b1;
    bus.i_data_addr = 32'h600; bus.i_mem_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mid();
      chk("g_mf_grant", bus.o_data_grant, 0);
      if (k > 0) chk("g_mf_en", bus.o_mem_enable, 0);
      if (k < 2) cyc();
    end
    cyc();
    bus.i_mem_full = 1'b0;
    mid();
    chk("g_drop_grant", bus.o_data_grant, 1);
    chk("g_drop_en", bus.o_mem_enable, 0);
    cyc();
    bus.i_data_enable = 1'b0;
    mid();
    chk("g_issue_en", bus.o_mem_enable, 1);
    chk("g_issue_wr", bus.o_mem_write, 1);
    do_reset();

    for (int c = 0; c < 3000; c++) begin
      cyc();
      if (!bus.i_instr_enable || eg_i) begin
        bus.i_instr_enable = ($urandom_range(0, 2) != 0);
        bus.i_instr_addr   = $urandom;
      end
      if (!bus.i_data_enable || eg_d) begin
        bus.i_data_enable = ($urandom_range(0, 2) != 0);
        bus.i_data_write  = ($urandom_range(0, 1) == 1);
        bus.i_data_addr   = $urandom;
        bus.i_data        = {$urandom, $urandom, $urandom, $urandom};
      end
      bus.i_mem_full = ($urandom_range(0, 4) == 0);
      t = $urandom_range(0, NUM_TAGS - 1);
      bus.i_resp_enable = mv[t] && ($urandom_range(0, 1) == 1);
      bus.i_resp_id     = t[ID_WIDTH-1:0];
      bus.i_ack_instr = mv[lid_i] && !mo[lid_i] &&
                        ($urandom_range(0, 3) == 0);
      bus.i_ack_data  = mv[lid_d] && mo[lid_d] &&
                        ($urandom_range(0, 3) == 0);
    end
    cyc();
    clear_inputs();
    mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
